// File: rtl/factorial_pkg.sv
// Shared definitions for the factorial sequencer: state encoding,
// accumulator mux select values and default sizing.
package factorial_pkg;

    localparam int WIDTH_DEFAULT = 8;
    // Largest n whose factorial fits in 8 bits (5! = 120)
    localparam int MAX_N_DEFAULT = 5;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_CHECK = 3'd2,
        S_MUL   = 3'd3,
        S_WAIT  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    // Accumulator mux: constant 8'h01 or multiplier product
    localparam logic ACC_SEL_INIT = 1'b0;
    localparam logic ACC_SEL_MUL  = 1'b1;

endpackage

// File: rtl/fact_dn_cnt.sv
// Loadable down-counter supplying the multiplier operand.
// It saturates at 1: a decrement request with q<=1 is ignored, so the
// counter can never wrap.
module fact_dn_cnt
    import factorial_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             dec,
    output logic [WIDTH-1:0] q,
    output logic             le1
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    assign q   = cnt_q;
    // q <= 1 exactly when all bits above bit 0 are clear
    assign le1 = (cnt_q[WIDTH-1:1] == '0);

    // Next count: load wins over decrement; decrement only above 1
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = d;
        end else if (dec && !le1) begin
            cnt_d = cnt_q - ONE;
        end
    end

    // Counter register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/factorial_ctrl.sv
// Sequencing FSM for the 8-bit factorial datapath. Drives the accumulator
// mux select and write enable, owns the operand down-counter and
// handshakes with an external multiplier.
// Optional feature macro: FACT_OVF_CHECK_EN -- when defined, a start with
// n > MAX_N goes straight to DONE and raises a sticky ovf flag; when
// undefined, ovf is tied low and every n is processed.
module factorial_ctrl
    import factorial_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
`ifdef FACT_OVF_CHECK_EN
    ,
    parameter int MAX_N = MAX_N_DEFAULT
`endif
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] n,
    input  logic             mul_done,
    output logic             busy,
    output logic             done,
    output logic             mul_start,
    output logic [WIDTH-1:0] op_b,
    output logic             acc_sel,
    output logic             acc_we,
    output logic             ovf
);

    state_t           state_q;
    state_t           state_d;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_le1;
    logic [WIDTH-1:0] cnt;

    fact_dn_cnt #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (cnt_load),
        .d       (n),
        .dec     (cnt_dec),
        .q       (cnt),
        .le1     (cnt_le1)
    );

    // The counter value is the multiplier operand; it only changes on
    // load (IDLE) or after mul_done, so it is stable from MUL through WAIT
    assign op_b = cnt;

`ifdef FACT_OVF_CHECK_EN
    localparam logic [WIDTH-1:0] MAX_N_W = WIDTH'(MAX_N);

    logic ovf_q;
    logic ovf_d;

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    // Next-state and output decode; every output defaults low
    always_comb begin
        state_d   = state_q;
        busy      = (state_q != S_IDLE);
        done      = 1'b0;
        mul_start = 1'b0;
        acc_sel   = ACC_SEL_INIT;
        acc_we    = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
`ifdef FACT_OVF_CHECK_EN
        ovf_d     = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_load = 1'b1;
`ifdef FACT_OVF_CHECK_EN
                    // Result would not fit: report and skip the datapath
                    if (n > MAX_N_W) begin
                        ovf_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        ovf_d   = 1'b0;
                        state_d = S_INIT;
                    end
`else
                    state_d = S_INIT;
`endif
                end
            end
            S_INIT: begin
                acc_sel = ACC_SEL_INIT;
                acc_we  = 1'b1;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                state_d = cnt_le1 ? S_DONE : S_MUL;
            end
            S_MUL: begin
                mul_start = 1'b1;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                // No timeout: the multiplier is trusted to answer
                if (mul_done) begin
                    acc_sel = ACC_SEL_MUL;
                    acc_we  = 1'b1;
                    cnt_dec = 1'b1;
                    state_d = S_CHECK;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; reset aborts any run in progress
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef FACT_OVF_CHECK_EN
    // Sticky overflow flag, cleared by reset or any accepted start
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end
`endif

endmodule
